// File: rtl/parity_frame_receiver_if.sv
// parity_frame_receiver_if: serial line, sample strobe and decoded frame outputs
interface parity_frame_receiver_if #(parameter int DATA_WIDTH = 8);
   logic                  serial_in;
   logic                  bit_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  parity_err;
   logic                  frame_err;
   logic                  busy;
   modport master (output serial_in, bit_en, input data_out, data_valid, parity_err, frame_err, busy);
   modport slave (input serial_in, bit_en, output data_out, data_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/parity_frame_receiver.sv
// parity_frame_receiver: start/data/parity/stop frame decoder sampling on bit_en
module parity_frame_receiver #(
   parameter int DATA_WIDTH = 8,
   parameter int ODD_PARITY = 0
) (
   input logic clk,
   input logic reset,
   parity_frame_receiver_if.slave bus
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
   localparam logic ODD = (ODD_PARITY != 0);
   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DONE, WAIT_IDLE} state_t;
   state_t state;
   logic [CW-1:0] count;
   logic [DATA_WIDTH-1:0] shreg;
   logic rpar;
   logic perr;
   assign bus.busy = (state != IDLE);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         shreg <= '0;
         rpar <= 1'b0;
         perr <= 1'b0;
         bus.data_out <= '0;
         bus.data_valid <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         bus.data_valid <= 1'b0;
         case (state)
            IDLE:
               if (bus.bit_en && !bus.serial_in) begin
                  state <= DATA;
                  count <= '0;
                  rpar <= 1'b0;
               end
            DATA:
               if (bus.bit_en) begin
                  for (int i = 0; i < DATA_WIDTH; i++)
                     if (count == CW'(i)) shreg[i] <= bus.serial_in;
                  rpar <= rpar ^ bus.serial_in;
                  count <= count + 1'b1;
                  if (count == LAST) state <= PARITY;
               end
            PARITY:
               if (bus.bit_en) begin
                  perr <= rpar ^ bus.serial_in ^ ODD;
                  state <= STOP;
               end
            STOP:
               if (bus.bit_en) begin
                  state <= DONE;
                  bus.data_valid <= 1'b1;
                  bus.data_out <= shreg;
                  bus.parity_err <= perr;
                  bus.frame_err <= !bus.serial_in;
               end
            // DONE ignores bit_en so a start bit cannot follow the stop bit directly
            DONE: state <= bus.frame_err ? WAIT_IDLE : IDLE;
            WAIT_IDLE: if (bus.bit_en && bus.serial_in) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_parity_frame_receiver.sv
// tb_parity_frame_receiver: directed frames into even- and odd-parity receivers
module tb_parity_frame_receiver;
   logic clk = 1'b0;
   logic reset;
   logic line;
   logic en;
   int cyc = 0;
   int vectors = 0;
   int errs = 0;
   int pulses = 0;
   typedef struct {
      int due;
      logic [7:0] d;
      logic pe;
      logic po;
      logic fe;
   } exp_t;
   exp_t q[$];
   exp_t last;
   parity_frame_receiver_if #(.DATA_WIDTH(8)) if_e ();
   parity_frame_receiver_if #(.DATA_WIDTH(8)) if_o ();
   assign if_e.serial_in = line;
   assign if_e.bit_en = en;
   assign if_o.serial_in = line;
   assign if_o.bit_en = en;
   parity_frame_receiver #(.DATA_WIDTH(8), .ODD_PARITY(0)) u_even (.clk(clk), .reset(reset), .bus(if_e.slave));
   parity_frame_receiver #(.DATA_WIDTH(8), .ODD_PARITY(1)) u_odd (.clk(clk), .reset(reset), .bus(if_o.slave));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // Reference: expected frame results are queued when the stop bit is driven
   always @(negedge clk) begin
      logic exp_dv;
      if (reset) begin
         last = '{0, 8'h00, 1'b0, 1'b0, 1'b0};
         chk("rst_dv_e", 16'(if_e.data_valid), 0);
         chk("rst_busy_e", 16'(if_e.busy), 0);
         chk("rst_dout_o", 16'(if_o.data_out), 0);
         chk("rst_busy_o", 16'(if_o.busy), 0);
      end else begin
         exp_dv = (q.size() > 0) && (q[0].due == cyc);
         if (exp_dv) last = q.pop_front();
         if (if_e.data_valid) pulses++;
         chk("dv_e", 16'(if_e.data_valid), 16'(exp_dv));
         chk("dv_o", 16'(if_o.data_valid), 16'(exp_dv));
         chk("dout_e", 16'(if_e.data_out), 16'(last.d));
         chk("dout_o", 16'(if_o.data_out), 16'(last.d));
         chk("perr_e", 16'(if_e.parity_err), 16'(last.pe));
         chk("perr_o", 16'(if_o.parity_err), 16'(last.po));
         chk("ferr_e", 16'(if_e.frame_err), 16'(last.fe));
         chk("ferr_o", 16'(if_o.frame_err), 16'(last.fe));
      end
   end
   // One bit period is four clocks with the strobe in the first
   task automatic drive_bit(input logic b);
      line = b;
      en = 1'b1;
      @(posedge clk);
      #1 en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int stall_after);
      exp_t e;
      drive_bit(1'b0);
      chk("busy_start", 16'(if_e.busy), 1);
      for (int i = 0; i < 8; i++) begin
         drive_bit(d[i]);
         if (i == stall_after) begin
            repeat (50) @(posedge clk);
            #1;
         end
      end
      drive_bit(p);
      e.due = cyc + 1;
      e.d = d;
      e.pe = (^d) ^ p;
      e.po = ~((^d) ^ p);
      e.fe = ~s;
      q.push_back(e);
      drive_bit(s);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   initial begin
      reset = 1'b1;
      line = 1'b1;
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      drive_bit(1'b1);
      send_frame(8'hA5, 1'b0, 1'b1, -1);
      chk("a5_data", 16'(if_e.data_out), 16'h00A5);
      chk("a5_perr_e", 16'(if_e.parity_err), 0);
      chk("a5_perr_o", 16'(if_o.parity_err), 1);
      chk("a5_ferr", 16'(if_e.frame_err), 0);
      chk("a5_busy", 16'(if_e.busy), 0);
      send_frame(8'h01, 1'b0, 1'b1, -1);
      chk("01_data", 16'(if_e.data_out), 16'h0001);
      chk("01_perr_e", 16'(if_e.parity_err), 1);
      chk("01_perr_o", 16'(if_o.parity_err), 0);
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      chk("3c_data", 16'(if_e.data_out), 16'h003C);
      chk("3c_ferr", 16'(if_e.frame_err), 1);
      chk("3c_perr_e", 16'(if_e.parity_err), 0);
      repeat (5) drive_bit(1'b0);
      chk("break_busy", 16'(if_e.busy), 1);
      drive_bit(1'b1);
      chk("break_end_busy", 16'(if_e.busy), 0);
      send_frame(8'h55, 1'b0, 1'b1, -1);
      chk("55_data", 16'(if_e.data_out), 16'h0055);
      chk("55_ferr", 16'(if_e.frame_err), 0);
      drive_bit(1'b0);
      repeat (4) drive_bit(1'b1);
      reset = 1'b1;
      #1;
      chk("async_rst_data", 16'(if_e.data_out), 0);
      chk("async_rst_busy", 16'(if_e.busy), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      drive_bit(1'b1);
      send_frame(8'h12, 1'b0, 1'b1, -1);
      chk("12_data", 16'(if_e.data_out), 16'h0012);
      repeat (20) drive_bit(1'b1);
      chk("idle_busy", 16'(if_e.busy), 0);
      send_frame(8'hC3, 1'b0, 1'b1, 3);
      chk("c3_data", 16'(if_e.data_out), 16'h00C3);
      chk("c3_perr_e", 16'(if_e.parity_err), 0);
      send_frame(8'h80, 1'b1, 1'b1, -1);
      chk("80_data", 16'(if_e.data_out), 16'h0080);
      drive_bit(1'b1);
      send_frame(8'h7F, 1'b1, 1'b1, -1);
      chk("7f_data", 16'(if_e.data_out), 16'h007F);
      chk("7f_perr_e", 16'(if_e.parity_err), 0);
      repeat (3) drive_bit(1'b1);
      chk("pulse_count", 16'(pulses), 8);
      chk("queue_drained", 16'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/parity_frame_receiver.md
PARITY_FRAME_RECEIVER -- requirements
Module: parity_frame_receiver

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of payload bits per frame (legal range 1..16).
REQ-002 The block SHALL have parameter ODD_PARITY, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  is the asynchronous, active-high reset.
REQ-006 serial_in  input  1  is the serial line, idle high, already synchronised to clk.
REQ-007 bit_en  input  1  is the bit-sample strobe; serial_in SHALL be sampled only in cycles where bit_en=1.
REQ-008 data_out  output  DATA_WIDTH  is the last received payload, LSB = first data bit received.
REQ-009 data_valid  output  1  is a one-cycle pulse marking a completed frame.
REQ-010 parity_err  output  1  marks a parity mismatch; it is qualified by data_valid.
REQ-011 frame_err  output  1  marks a stop bit sampled low; it is qualified by data_valid.
REQ-012 busy  output  1  is high whenever the state is not IDLE.

Function
REQ-013 The frame format SHALL be:
- start bit (0)
- DATA_WIDTH data bits, LSB first
- one parity bit
- one stop bit (1)
REQ-014 The FSM SHALL use states IDLE, DATA, PARITY, STOP, DONE and WAIT_IDLE.
REQ-015 IDLE SHALL go to DATA when serial_in=0 is sampled on bit_en; a sampled 1 SHALL leave the state in IDLE.
REQ-016 In DATA, each sampled bit SHALL be shifted into bit position count of the shift register, where count runs 0..DATA_WIDTH-1.
REQ-017 In DATA, each sampled bit SHALL also be XORed into a running parity register that is cleared on entry to DATA.
REQ-018 After the bit at count=DATA_WIDTH-1 is sampled, DATA SHALL go to PARITY; the counter SHALL be wide enough for DATA_WIDTH with no wrap before then.
REQ-019 PARITY SHALL sample the parity bit, set perr = running_parity XOR parity_bit XOR ODD_PARITY, and go to STOP.
REQ-020 STOP SHALL sample the stop bit, set ferr = NOT stop_bit, and go to DONE.
REQ-021 DONE SHALL last exactly one cycle, independent of bit_en, and in that cycle:
- data_valid=1
- data_out = the shift register
- parity_err = perr
- frame_err = ferr
REQ-022 DONE SHALL go to IDLE when ferr=0, and to WAIT_IDLE when ferr=1.
REQ-023 WAIT_IDLE SHALL go to IDLE only when serial_in=1 is sampled on bit_en; a low line (break) SHALL never start a new frame.
REQ-024 Cycles with bit_en=0 SHALL hold all state except the DONE→next transition.
REQ-025 data_out, parity_err and frame_err SHALL hold their DONE values until the next DONE; data_valid SHALL be 0 outside DONE.
REQ-026 Latency SHALL be one clk from the stop-bit sample edge to data_valid=1.
REQ-027 A bit_en arriving during DONE SHALL be ignored (a start bit needs at least one bit period after the stop bit).
REQ-028 Frame errors SHALL NOT suppress the parity check; both error flags MAY be 1 in the same DONE cycle.

Reset
REQ-029 While reset=1, and asynchronously on its assertion, the block SHALL force:
- state=IDLE
- count=0
- running parity=0
- data_out=0
- data_valid=0
- parity_err=0
- frame_err=0
- busy=0
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no data_valid pulse.
REQ-031 The first frame after reset deassertion SHALL be received normally.

Verification
REQ-032 The bench SHALL cover these directed scenarios (DATA_WIDTH=8, ODD_PARITY=0 unless noted):
- Frame 0xA5, parity 0, stop 1, bit_en every 4th cycle -> one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0; busy high from the start bit to DONE.
- Frame 0x01 with parity bit 0 -> data_valid, data_out=0x01, parity_err=1; repeat with ODD_PARITY=1 -> parity_err=0.
- Frame 0x3C with stop bit 0, line held low for 5 bit periods, then high -> frame_err=1; no new frame while low; a following 0x55 frame is received correctly.
- Reset pulsed after the 4th data bit of a 0xFF frame -> all outputs 0, no data_valid; the next 0x12 frame yields data_out=0x12.
- Line held 1 with bit_en toggling for 20 periods -> busy=0, no data_valid; bit_en=0 for 50 cycles mid-frame -> frame still decodes correctly.
- Two back-to-back frames 0x80, 0x7F with one idle bit between -> two data_valid pulses with the correct values.
